// File: rtl/acia_sram_loader.sv
// acia_sram_loader: serial monitor that polls the ACIA and runs W/R peek/poke commands on the SRAM.
// Rev 1.0 -- optional pointer commands 'w'/'r' and auto-increment enabled by `define ADDR_AUTOINC_EN.
`default_nettype none

module acia_sram_loader #(
  parameter logic [7:0]  INIT_CTRL      = 8'h15,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd4000000,
  parameter int          SRAM_RD_LAT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_mode,
  output logic        acia_cs,
  output logic        acia_we,
  output logic        acia_rs,
  output logic [7:0]  acia_din,
  input  logic [7:0]  acia_dout,
  output logic [15:0] sram_addr,
  output logic [7:0]  sram_dout,
  output logic        sram_we,
  output logic        sram_oe,
  input  logic [7:0]  sram_din,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam logic [7:0] c_OP_W     = 8'h57;
  localparam logic [7:0] c_OP_R     = 8'h52;
`ifdef ADDR_AUTOINC_EN
  localparam logic [7:0] c_OP_WI    = 8'h77;
  localparam logic [7:0] c_OP_RI    = 8'h72;
`endif
  localparam logic [7:0] c_RPL_OK   = 8'h2E;
  localparam logic [7:0] c_RPL_ERR  = 8'h3F;
  localparam logic [7:0] c_MR_WORD  = 8'h03;
  localparam logic [3:0] c_LAT_LAST = 4'(SRAM_RD_LAT - 1);

  typedef enum logic [3:0] {
    S_INIT_MR, S_INIT_CFG, S_POLL_RX, S_RX_STAT, S_RD_DATA, S_CAPTURE,
    S_SRAM_WR, S_SRAM_RD, S_POLL_TX, S_TX_STAT, S_TX_END, S_ACC_END
  } state_t;

  state_t      r_state, r_ret;
  logic        r_cs, r_we, r_rs;
  logic [7:0]  r_din;
  logic [15:0] r_addr;
  logic [7:0]  r_dout;
  logic        r_swe, r_soe;
  logic        r_busy, r_collect;
  logic [7:0]  r_err;
  logic [7:0]  r_op;
  logic [7:0]  r_reply;
  logic [1:0]  r_cnt, r_need;
  logic [23:0] r_tmo;
  logic [3:0]  r_lat;
`ifdef ADDR_AUTOINC_EN
  logic [15:0] r_ptr;
`endif

  logic [7:0] w_err_inc;
  logic [1:0] w_need;
  logic       w_known;
  logic [1:0] w_cnt_nxt;
  logic       w_last;

  assign w_err_inc = (r_err == 8'hFF) ? r_err : r_err + 8'd1;
  assign w_cnt_nxt = r_cnt + 2'd1;
  assign w_last    = (w_cnt_nxt == r_need);

  // Number of operand bytes that follow each opcode
  always_comb begin
    w_known = 1'b1;
    w_need  = 2'd0;
    case (acia_dout)
      c_OP_W:  w_need = 2'd3;
      c_OP_R:  w_need = 2'd2;
`ifdef ADDR_AUTOINC_EN
      c_OP_WI: w_need = 2'd1;
      c_OP_RI: w_need = 2'd0;
`endif
      default: w_known = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_INIT_MR;
      r_ret     <= S_INIT_MR;
      r_cs      <= 1'b0;
      r_we      <= 1'b0;
      r_rs      <= 1'b0;
      r_din     <= 8'h00;
      r_addr    <= 16'h0000;
      r_dout    <= 8'h00;
      r_swe     <= 1'b0;
      r_soe     <= 1'b0;
      r_busy    <= 1'b0;
      r_collect <= 1'b0;
      r_err     <= 8'h00;
      r_op      <= 8'h00;
      r_reply   <= 8'h00;
      r_cnt     <= 2'd0;
      r_need    <= 2'd0;
      r_tmo     <= 24'd0;
      r_lat     <= 4'd0;
`ifdef ADDR_AUTOINC_EN
      r_ptr     <= 16'h0000;
`endif
    end else begin
      if (r_collect && r_tmo != '1) r_tmo <= r_tmo + 24'd1;
      case (r_state)
        S_INIT_MR: if (load_mode) begin
          r_cs <= 1'b1; r_we <= 1'b1; r_rs <= 1'b0; r_din <= c_MR_WORD;
          r_ret <= S_INIT_CFG; r_state <= S_ACC_END;
        end
        S_INIT_CFG: if (load_mode) begin
          r_cs <= 1'b1; r_we <= 1'b1; r_rs <= 1'b0; r_din <= INIT_CTRL;
          r_ret <= S_POLL_RX; r_state <= S_ACC_END;
        end
        S_POLL_RX: begin
          if (!load_mode) begin
            r_busy <= 1'b0; r_collect <= 1'b0;
          end else if (r_collect && r_tmo >= TIMEOUT_CYCLES) begin
            r_busy <= 1'b0; r_collect <= 1'b0; r_err <= w_err_inc;
          end else begin
            r_cs <= 1'b1; r_we <= 1'b0; r_rs <= 1'b0;
            r_ret <= S_RX_STAT; r_state <= S_ACC_END;
          end
        end
        S_RX_STAT: r_state <= (acia_dout[0] && load_mode) ? S_RD_DATA : S_POLL_RX;
        S_RD_DATA: begin
          r_cs <= 1'b1; r_we <= 1'b0; r_rs <= 1'b1;
          r_ret <= S_CAPTURE; r_state <= S_ACC_END;
        end
        S_CAPTURE: begin
          r_state <= S_POLL_RX;
          if (!load_mode) begin
            r_busy <= 1'b0; r_collect <= 1'b0;
          end else if (!r_busy) begin
            r_busy <= 1'b1; r_op <= acia_dout; r_cnt <= 2'd0; r_need <= w_need; r_tmo <= 24'd0;
            if (!w_known) begin
              r_reply <= c_RPL_ERR; r_err <= w_err_inc; r_state <= S_POLL_TX;
`ifdef ADDR_AUTOINC_EN
            end else if (w_need == 2'd0) begin
              r_addr <= r_ptr; r_ptr <= r_ptr + 16'd1;
              r_soe <= 1'b1; r_lat <= 4'd0; r_state <= S_SRAM_RD;
`endif
            end else begin
              r_collect <= 1'b1;
            end
          end else begin
            r_tmo <= 24'd0;
            r_cnt <= w_cnt_nxt;
            if (r_op == c_OP_W || r_op == c_OP_R) begin
              case (r_cnt)
                2'd0:    r_addr[15:8] <= acia_dout;
                2'd1:    r_addr[7:0]  <= acia_dout;
                default: r_dout       <= acia_dout;
              endcase
            end else begin
              r_dout <= acia_dout;
            end
            if (w_last) begin
              r_collect <= 1'b0;
              if (r_op == c_OP_R) begin
                r_soe <= 1'b1; r_lat <= 4'd0; r_state <= S_SRAM_RD;
`ifdef ADDR_AUTOINC_EN
                r_ptr <= {r_addr[15:8], acia_dout} + 16'd1;
`endif
              end else begin
                r_swe <= 1'b1; r_state <= S_SRAM_WR;
`ifdef ADDR_AUTOINC_EN
                if (r_op == c_OP_WI) begin
                  r_addr <= r_ptr; r_ptr <= r_ptr + 16'd1;
                end else begin
                  r_ptr <= r_addr + 16'd1;
                end
`endif
              end
            end
          end
        end
        S_SRAM_WR: begin
          r_swe <= 1'b0; r_reply <= c_RPL_OK; r_state <= S_POLL_TX;
        end
        S_SRAM_RD: begin
          if (r_lat == c_LAT_LAST) begin
            r_reply <= sram_din; r_soe <= 1'b0; r_state <= S_POLL_TX;
          end else begin
            r_lat <= r_lat + 4'd1;
          end
        end
        S_POLL_TX: begin
          if (!load_mode) begin
            r_busy <= 1'b0; r_state <= S_POLL_RX;
          end else begin
            r_cs <= 1'b1; r_we <= 1'b0; r_rs <= 1'b0;
            r_ret <= S_TX_STAT; r_state <= S_ACC_END;
          end
        end
        S_TX_STAT: begin
          if (acia_dout[1] && load_mode) begin
            r_cs <= 1'b1; r_we <= 1'b1; r_rs <= 1'b1; r_din <= r_reply;
            r_state <= S_TX_END;
          end else begin
            r_state <= S_POLL_TX;
          end
        end
        S_TX_END: begin
          r_cs <= 1'b0; r_we <= 1'b0; r_busy <= 1'b0; r_state <= S_POLL_RX;
        end
        S_ACC_END: begin
          r_cs <= 1'b0; r_we <= 1'b0; r_state <= r_ret;
        end
        default: r_state <= S_POLL_RX;
      endcase
    end
  end

  assign acia_cs   = r_cs;
  assign acia_we   = r_we;
  assign acia_rs   = r_rs;
  assign acia_din  = r_din;
  assign sram_addr = r_addr;
  assign sram_dout = r_dout;
  assign sram_we   = r_swe;
  assign sram_oe   = r_soe;
  assign busy      = r_busy;
  assign err_cnt   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_acia_sram_loader.sv
// tb_acia_sram_loader: ACIA/SRAM bus models plus a command-level reference model for acia_sram_loader.
`default_nettype none
`timescale 1ns/1ps

module tb_acia_sram_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_mode = 1'b1;
  logic        acia_cs, acia_we, acia_rs;
  logic [7:0]  acia_din;
  logic [7:0]  acia_dout = 8'h00;
  logic [15:0] sram_addr;
  logic [7:0]  sram_dout;
  logic        sram_we, sram_oe;
  logic [7:0]  sram_din;
  logic        busy;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  acia_sram_loader #(.INIT_CTRL(8'h15), .TIMEOUT_CYCLES(24'd100), .SRAM_RD_LAT(2)) u_dut (
    .clk(clk), .reset(reset), .load_mode(load_mode),
    .acia_cs(acia_cs), .acia_we(acia_we), .acia_rs(acia_rs), .acia_din(acia_din),
    .acia_dout(acia_dout), .sram_addr(sram_addr), .sram_dout(sram_dout),
    .sram_we(sram_we), .sram_oe(sram_oe), .sram_din(sram_din),
    .busy(busy), .err_cnt(err_cnt)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- bus models ----------------
  logic [7:0]  rx_q[$];
  logic [8:0]  wr_q[$];
  logic [7:0]  reply_q[$];
  bit          tdre = 1'b1;
  int          status_reads = 0;
  int          cs_count = 0;
  int          we_cycles = 0;
  int          oe_cycles = 0;
  logic [15:0] last_we_addr = 16'h0;
  logic [7:0]  last_we_data = 8'h0;
  logic [7:0]  mem [0:65535];
  logic        oe_d1 = 1'b0;
  int          oe_run = 0;
  int          last_oe_run = 0;
  logic [15:0] oe_addr = 16'h0;

  always @(posedge clk) begin
    if (acia_cs) begin
      cs_count <= cs_count + 1;
      if (acia_we) begin
        wr_q.push_back({acia_rs, acia_din});
        if (acia_rs) reply_q.push_back(acia_din);
      end else if (!acia_rs) begin
        acia_dout    <= {6'd0, tdre, (rx_q.size() != 0)};
        status_reads <= status_reads + 1;
      end else begin
        acia_dout <= (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
      end
    end
    if (sram_we) begin
      mem[sram_addr] <= sram_dout;
      we_cycles      <= we_cycles + 1;
      last_we_addr   <= sram_addr;
      last_we_data   <= sram_dout;
    end
    oe_d1 <= sram_oe;
    if (sram_oe) begin
      oe_run    <= oe_run + 1;
      oe_cycles <= oe_cycles + 1;
      oe_addr   <= sram_addr;
    end else if (oe_run != 0) begin
      last_oe_run <= oe_run;
      oe_run      <= 0;
    end
  end

  // Data is only valid once output enable has been held for a full clock
  assign sram_din = (sram_oe && oe_d1) ? mem[sram_addr] : 8'hEE;

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] ref_ptr = 16'h0;
  int          ref_err = 0;
  bit          autoinc;

  task automatic ref_cmd(input logic [7:0] op, hi, lo, d, output logic [7:0] rep, output int nbytes);
    logic [15:0] a;
    a = {hi, lo};
    if (op == 8'h57) begin
      ref_mem[a] = d; ref_ptr = a + 16'd1; rep = 8'h2E; nbytes = 4;
    end else if (op == 8'h52) begin
      rep = ref_mem[a]; ref_ptr = a + 16'd1; nbytes = 3;
    end else if (autoinc && op == 8'h77) begin
      ref_mem[ref_ptr] = hi; ref_ptr = ref_ptr + 16'd1; rep = 8'h2E; nbytes = 2;
    end else if (autoinc && op == 8'h72) begin
      rep = ref_mem[ref_ptr]; ref_ptr = ref_ptr + 16'd1; nbytes = 1;
    end else begin
      ref_err = (ref_err < 255) ? ref_err + 1 : 255; rep = 8'h3F; nbytes = 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic get_reply(input string tag, output logic [7:0] r);
    bit got;
    got = 1'b0;
    r = 8'h00;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (reply_q.size() != 0) begin
        r = reply_q.pop_front();
        got = 1'b1;
      end
    end
    check({tag, "_arrived"}, 32'(got), 32'd1);
  endtask

  // For 'w' the data byte travels in the hi slot
  task automatic do_cmd(input string tag, input logic [7:0] op, hi, lo, d);
    logic [7:0] exp_rep, got_rep;
    int n;
    ref_cmd(op, hi, lo, d, exp_rep, n);
    rx_q.push_back(op);
    if (n >= 2) rx_q.push_back(hi);
    if (n >= 3) rx_q.push_back(lo);
    if (n >= 4) rx_q.push_back(d);
    get_reply(tag, got_rep);
    check({tag, "_reply"}, 32'(got_rep), 32'(exp_rep));
    check({tag, "_err"}, 32'(err_cnt), 32'(ref_err));
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] r;
    int sr0, cs0, we0;
    bit ok;
`ifdef ADDR_AUTOINC_EN
    autoinc = 1'b1;
`else
    autoinc = 1'b0;
`endif
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end

    // Reset state
    wait_clks(4);
    check("rst_acia_cs", 32'(acia_cs), 32'd0);
    check("rst_sram_we", 32'(sram_we), 32'd0);
    check("rst_sram_oe", 32'(sram_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);

    // Init sequence: MR then control word, then status polling
    reset = 1'b1;
    wait_clks(20);
    check("init_nwrites", 32'(wr_q.size()), 32'd2);
    if (wr_q.size() >= 2) begin
      check("init_mr", 32'(wr_q[0]), 32'h003);
      check("init_cfg", 32'(wr_q[1]), 32'h015);
    end
    check("init_polling", 32'(status_reads > 0), 32'd1);
    check("init_no_sram", 32'(we_cycles + oe_cycles), 32'd0);
    wr_q.delete();

    // Write with TX held busy for 500 clocks
    tdre = 1'b0;
    ref_cmd(8'h57, 8'h12, 8'h34, 8'hA5, r, sr0);
    rx_q.push_back(8'h57); rx_q.push_back(8'h12); rx_q.push_back(8'h34); rx_q.push_back(8'hA5);
    sr0 = status_reads;
    wait_clks(500);
    check("tdre_hold_polls", 32'(status_reads - sr0 > 100), 32'd1);
    check("tdre_hold_noreply", 32'(reply_q.size()), 32'd0);
    check("tdre_hold_busy", 32'(busy), 32'd1);
    check("w_we_cycles", 32'(we_cycles), 32'd1);
    check("w_addr", 32'(last_we_addr), 32'h1234);
    check("w_data", 32'(last_we_data), 32'hA5);
    tdre = 1'b1;
    get_reply("w_tdre", r);
    check("w_reply", 32'(r), 32'h2E);
    wait_clks(2);
    check("w_busy_low", 32'(busy), 32'd0);

    // Read back with two-clock SRAM latency
    do_cmd("r1234", 8'h52, 8'h12, 8'h34, 8'h00);
    check("r_oe_len", 32'(last_oe_run), 32'd2);
    check("r_oe_addr", 32'(oe_addr), 32'h1234);

    // Bad opcode, then timeout
    do_cmd("bad00", 8'h00, 8'h00, 8'h00, 8'h00);
    rx_q.push_back(8'h57); rx_q.push_back(8'h12);
    wait_clks(300);
    ref_err = ref_err + 1;
    check("tmo_noreply", 32'(reply_q.size()), 32'd0);
    check("tmo_err", 32'(err_cnt), 32'(ref_err));
    check("tmo_busy", 32'(busy), 32'd0);
    do_cmd("after_tmo", 8'h52, 8'h12, 8'h34, 8'h00);

    // load_mode dropped mid-'W'
    we0 = we_cycles;
    rx_q.push_back(8'h57); rx_q.push_back(8'h12);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = (rx_q.size() == 0);
    end
    check("lm_consumed", 32'(ok), 32'd1);
    wait_clks(10);
    load_mode = 1'b0;
    wait_clks(6);
    cs0 = cs_count;
    wait_clks(60);
    check("lm_no_cs", 32'(cs_count - cs0), 32'd0);
    check("lm_no_we", 32'(we_cycles - we0), 32'd0);
    check("lm_busy", 32'(busy), 32'd0);
    check("lm_err", 32'(err_cnt), 32'(ref_err));
    check("lm_no_reply", 32'(reply_q.size()), 32'd0);
    load_mode = 1'b1;
    do_cmd("lm_after", 8'h52, 8'h12, 8'h34, 8'h00);

    // Randomised W/R traffic over a small address window
    for (int i = 0; i < 40; i++) begin
      logic [7:0] op, lo, d;
      int sel;
      sel = autoinc ? $urandom_range(3, 0) : $urandom_range(1, 0);
      op = (sel == 0) ? 8'h57 : (sel == 1) ? 8'h52 : (sel == 2) ? 8'h77 : 8'h72;
      lo = 8'($urandom_range(31, 0));
      d  = 8'($urandom);
      if (sel == 2) do_cmd("rand", op, d, 8'h00, 8'h00);
      else          do_cmd("rand", op, 8'h40, lo, d);
    end

`ifdef ADDR_AUTOINC_EN
    do_cmd("ai_wffff", 8'h57, 8'hFF, 8'hFF, 8'h11);
    do_cmd("ai_wptr", 8'h77, 8'h22, 8'h00, 8'h00);
    check("ai_wrap_addr", 32'(last_we_addr), 32'h0000);
    do_cmd("ai_rffff", 8'h52, 8'hFF, 8'hFF, 8'h00);
    do_cmd("ai_rptr", 8'h72, 8'h00, 8'h00, 8'h00);
`else
    do_cmd("no_ai_w", 8'h77, 8'h00, 8'h00, 8'h00);
    do_cmd("no_ai_r", 8'h72, 8'h00, 8'h00, 8'h00);
`endif

    // Saturate the error counter
    for (int i = 0; i < 300; i++) begin
      logic [7:0] op;
      op = 8'($urandom);
      if (op == 8'h57 || op == 8'h52 || op == 8'h77 || op == 8'h72) op = 8'h00;
      do_cmd("sat", op, 8'h00, 8'h00, 8'h00);
    end
    check("err_sat", 32'(err_cnt), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
